// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared types, constants and helpers for the seven-segment driver
package seven_segment_pkg;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Clocks per digit slot for a given clock frequency (Hz) and dwell time (us).
    function automatic int dwell_clocks(input int freq, input int us);
        return freq / 1_000_000 * us;
    endfunction

    // Active-low segment pattern, bit 6 = A down to bit 0 = G.
    function automatic logic [6:0] hex_to_segments(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_segment_refresh_timer.sv
// rtl/seven_segment_refresh_timer.sv - dwell counter producing a tick on the last cycle of each digit slot
import seven_segment_pkg::*;

module seven_segment_refresh_timer #(
    parameter int DWELL_CLOCKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DWELL_CLOCKS > 2) ? $clog2(DWELL_CLOCKS) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DWELL_CLOCKS - 1));

    // Count 0..DWELL_CLOCKS-1 while the scan is running, wrapping on tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seven_segment_ctrl.sv
// rtl/seven_segment_ctrl.sv - eight-digit seven-segment scan driver (option macro: SEVEN_SEGMENT_LEADING_ZERO_SUPPRESS_EN)
import seven_segment_pkg::*;

module seven_segment_ctrl #(
    parameter int CLK_FREQUENCY          = 100_000_000,
    parameter int MIN_SEGMENT_DISPLAY_US = 10_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display_val,
    input  logic [7:0]  dp,
    input  logic        blank,
    output logic [6:0]  segments,
    output logic        dp_out,
    output logic [7:0]  an_out,
    output logic        frame_done
);

    localparam int DWELL_CLOCKS = dwell_clocks(CLK_FREQUENCY, MIN_SEGMENT_DISPLAY_US);

    generate
        if (DWELL_CLOCKS < 2) begin : g_bad_dwell
            $error("seven_segment_ctrl: DWELL_CLOCKS must be at least 2");
        end
    endgenerate

    // running is low only for the first edge after reset, which starts a frame
    // without being the end of a previous one.
    logic        running;
    digit_idx_t  digit_idx;
    logic [31:0] val_snap;
    logic [7:0]  dp_snap;
    logic        blank_snap;
    logic        tick;

    logic        frame_start;
    digit_idx_t  next_idx;
    logic [31:0] src_val;
    logic [7:0]  src_dp;
    logic        src_blank;
    logic [3:0]  nib;
    logic        suppress;
    logic        zero_run;
    logic [7:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    seven_segment_refresh_timer #(
        .DWELL_CLOCKS(DWELL_CLOCKS)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (running),
        .tick(tick)
    );

    // Pick the digit shown after the next slot boundary; at a frame start the
    // live inputs are used since they become the snapshot on that same edge.
    always_comb begin
        frame_start = !running || (tick && (digit_idx == 3'd7));
        next_idx    = frame_start ? 3'd0 : digit_idx + 3'd1;
        src_val     = frame_start ? display_val : val_snap;
        src_dp      = frame_start ? dp : dp_snap;
        src_blank   = frame_start ? blank : blank_snap;
        nib         = src_val[{next_idx, 2'b00} +: 4];
        suppress    = 1'b0;
        zero_run    = 1'b1;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_SUPPRESS_EN
        for (int i = 7; i >= 1; i--) begin
            zero_run = zero_run && (src_val[4*i +: 4] == 4'h0);
            if (i == int'(next_idx)) begin
                suppress = zero_run && !src_dp[i];
            end
        end
`endif
        if (src_blank || suppress) begin
            an_nxt  = 8'hFF;
            seg_nxt = SEG_BLANK;
            dp_nxt  = 1'b1;
        end else begin
            an_nxt  = ~(8'h01 << next_idx);
            seg_nxt = hex_to_segments(nib);
            dp_nxt  = ~src_dp[next_idx];
        end
    end

    // Advance the digit on each slot boundary, capturing inputs at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running    <= 1'b0;
            digit_idx  <= '0;
            val_snap   <= '0;
            dp_snap    <= '0;
            blank_snap <= 1'b0;
            an_out     <= 8'hFF;
            segments   <= SEG_BLANK;
            dp_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && (digit_idx == 3'd7);
            if (frame_start) begin
                running    <= 1'b1;
                val_snap   <= display_val;
                dp_snap    <= dp;
                blank_snap <= blank;
            end
            if (frame_start || tick) begin
                digit_idx <= next_idx;
                an_out    <= an_nxt;
                segments  <= seg_nxt;
                dp_out    <= dp_nxt;
            end
        end
    end

endmodule
